// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_OP_DIV = 0;
  localparam int MDU_OP_UNS = 1;

  // Bits needed to hold the iteration count 0..width.
  function automatic int mdu_cnt_width(input int width);
    int r;
    r = 0;
    while ((1 << r) < (width + 1)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Two's-complement conditional negate: yields |val| for operand entry when neg_i
// flags a negative input, and applies the result sign on the way out.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// Define MDU_UNSIGNED_EN to honour op[1] as an unsigned-operation select.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = mdu_cnt_width(WIDTH);

  mdu_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic op_signed;
`ifdef MDU_UNSIGNED_EN
  assign op_signed = ~op[MDU_OP_UNS];
`else
  logic unused_op_uns;
  assign op_signed     = 1'b1;
  assign unused_op_uns = op[MDU_OP_UNS];
`endif

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign neg_a = op_signed & a[WIDTH-1];
  assign neg_b = op_signed & b[WIDTH-1];

  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.val_i(a), .neg_i(neg_a), .res_o(mag_a));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.val_i(b), .neg_i(neg_b), .res_o(mag_b));

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient};
  // opnd_q is the multiplicand or divisor magnitude.
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = trial - {1'b0, opnd_q};
    // trial < 2*divisor, so the borrow bit alone decides trial >= divisor.
    ge      = ~diff[WIDTH];
    if (div_q) begin
      acc_d = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end else begin
      acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res;
  logic [WIDTH-1:0]   rem_res;

  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .val_i(acc_d), .neg_i(neg_a_q ^ neg_b_q), .res_o(prod_res)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .val_i(acc_d[WIDTH-1:0]), .neg_i(neg_a_q ^ neg_b_q), .res_o(quot_res)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i(acc_d[2*WIDTH-1:WIDTH]), .neg_i(neg_a_q), .res_o(rem_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            div_q   <= op[MDU_OP_DIV];
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            opnd_q  <= op[MDU_OP_DIV] ? mag_b : mag_a;
            acc_q   <= {{WIDTH{1'b0}}, (op[MDU_OP_DIV] ? mag_a : mag_b)};
            if (op[MDU_OP_DIV] && (b == '0)) begin
              state_q <= MDU_DONE;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= MDU_RUN;
              dz_q    <= 1'b0;
            end
          end
        end
        MDU_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= MDU_DONE;
            done_q  <= 1'b1;
            if (div_q) begin
              hi_q <= rem_res;
              lo_q <= quot_res;
            end else begin
              hi_q <= prod_res[2*WIDTH-1:WIDTH];
              lo_q <= prod_res[WIDTH-1:0];
            end
          end
        end
        MDU_DONE: begin
          state_q <= MDU_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= MDU_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (WIDTH=32): directed and random MULT/DIV
// against a 64-bit arithmetic reference model; results checked on done pulses.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int NORM_LAT = W + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, sp;
    logic [63:0] ux, uy, up;
    logic uns;
    uns = 1'b0;
`ifdef MDU_UNSIGNED_EN
    uns = o[1];
`endif
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    e.dz = 1'b0;
    e.lat = NORM_LAT;
    e.acc = 0;
    if (!o[0]) begin
      if (uns) up = ux * uy;
      else     up = sx * sy;
      e.hi = up[63:32];
      e.lo = up[31:0];
    end else if (y == '0) begin
      e.dz = 1'b1;
      e.lat = 1;
      e.hi = mhi;
      e.lo = mlo;
    end else if (uns) begin
      up = ux / uy; e.lo = up[31:0];
      up = ux % uy; e.hi = up[31:0];
    end else begin
      sp = sx / sy; e.lo = sp[31:0];
      sp = sx % sy; e.hi = sp[31:0];
    end
    mhi = e.hi;
    mlo = e.lo;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_zero", div_zero, e.dz);
        check("latency_edges", cyc - e.acc + 1, e.lat);
      end
    end
  end

  // Called at a negedge; start is sampled on the following rising edge.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit intrude);
    exp_t e;
    int bc;
    bit got;
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    got = 1'b0;
    for (int n = 0; n < NORM_LAT + 15 && !got; n++) begin
      if (n > 0) begin
        @(negedge clk);
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) got = 1'b1;
      else if (intrude && $urandom_range(0, 2) == 0) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    check("busy_cycles", bc, e.lat);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);

    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(2'b01, 32'h0ACF_1234, 32'h0000_2000, 1'b0);
    do_op(2'b01, 32'd5, 32'd0, 1'b0);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'd3, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Abort a multiply in flight; the mid-flight start must be ignored.
    start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = $urandom; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_div_zero", div_zero, 0);
    reset = 1'b0;
    do_op(2'b01, 32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      ro = 2'($urandom);
      do_op(ro, pick(), pick(), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
